blink_round_sequencer: RTL and testbench
========================================

# blink_round_sequencer

Iterative round controller for the Blink-128 cipher core. It accepts one 128-bit block through a valid/ready handshake and applies the initial whitening key. It then drives a single shared round datapath (substitution layer followed by MixColumns_AddKey) once per cycle for NR rounds, and presents the result through a second valid/ready handshake. It sits between the core's I/O wrapper and the combinational round function, and it indexes the key-schedule store through `rk_idx`.

## Interface
- `NR`, default 16: number of rounds; legal range 1..31.
- `CW`, default `$clog2(NR+1)`: width of the round counter and `rk_idx`; derived, do not override.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: `in_data` holds a block to encrypt.
- `in_ready` output 1: block can be accepted this cycle.
- `in_data` input 128: plaintext block.
- `out_valid` output 1: `out_data` holds a finished ciphertext.
- `out_ready` input 1: consumer accepts `out_data` this cycle.
- `out_data` output 128: ciphertext, which is the state register.
- `rk_idx` output CW: round-key index requested from the key store.
- `rk` input 128: round key for `rk_idx`, combinational, valid in the same cycle.
- `rf_in` output 128: state fed to the round datapath, which is the state register.
- `rf_out` input 128: round datapath result for (`rf_in`, `rk`), combinational.
- `busy` output 1: high in RUN.
- `abort` input 1: present only with `BLINK_ABORT_EN`.

## Operation
- There are three states: IDLE, RUN and DONE. Registers are `st`, `state[127:0]` and `rnd[CW-1:0]`.
- IDLE:
  - `in_ready`=1 and `rk_idx`=0.
  - On `in_valid`: `state` <= `in_data` ^ `rk` (whitening), `rnd` <= 1, and the FSM goes to RUN.
- RUN:
  - `rk_idx`=`rnd` and `state` <= `rf_out` every cycle.
  - If `rnd`==NR, go to DONE. Otherwise `rnd` <= `rnd`+1.
  - `in_valid` is ignored because `in_ready`=0.
- DONE:
  - `out_valid`=1 and `rk_idx`=0. `state` is held until `out_ready`=1.
  - `in_ready`=`out_ready`, so a block can be accepted in the same cycle the result is consumed.
  - `out_ready`=1 and `in_valid`=1: load the new block (whitening) and go to RUN with `rnd`=1.
  - `out_ready`=1 and `in_valid`=0: go to IDLE. `state` is kept; its value is don't-care.
- `out_data`/`rf_in` is always the state register, with no extra output register.
- NR=1: RUN lasts exactly one cycle.

## Timing
- Reset values (cycle after `rst_n`=0 is sampled):
  - `st`=IDLE, `state`=0, `rnd`=0.
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `rk_idx`=0, `busy`=0.
- Latency: a block accepted at edge T gives `out_valid`=1 in the cycle after edge T+NR.
- Throughput: one block per NR+1 cycles with `out_ready` tied high.
- `out_valid` stays high and `out_data` stable until the `out_ready` handshake; both are independent of `out_ready` combinationally.
- `in_ready` depends combinationally on `out_ready` in DONE only.
- `rk` and `rf_out` must settle within the same cycle. The block adds no combinational path from `rk`/`rf_out` to any output.
- Reset asserted mid-RUN or in DONE: return to reset values at the next edge. The in-flight block is lost and `out_valid` is never raised for it.

## Configuration
- `BLINK_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in RUN or DONE: the next state is IDLE, `state`<=0 and `rnd`<=0. No output handshake occurs, even if `out_ready`=1 in the same cycle.
  - In IDLE, `abort` is ignored, so `abort` and `in_valid` together accept the block.
- `BLINK_ABORT_EN` undefined: the port does not exist and behaviour is exactly as above without abort.

## Test plan
- Reset, then release: `in_ready`=1, `out_valid`=0, `out_data`=0, `rk_idx`=0.
- NR=4, stub `rk`=0, `rf_out`=`rf_in`+1; accept `in_data`=0x10 at edge T:
  - `rk_idx` sequence is 1,2,3,4.
  - `out_valid`=1 after edge T+4 with `out_data`=0x14.
- Same setup, `rk`=`rk_idx` replicated in every byte:
  - Check the whitening uses key 0.
  - `out_data` = `in_data` ^ 0 + 4.
- Hold `out_ready`=0 for 5 cycles in DONE: `out_data` is stable and `in_ready`=0. Then assert `out_ready`=1 and `in_valid`=1 together: the new block is accepted and the next `out_valid` follows 4 cycles after the next edge.
- Assert `rst_n`=0 at round 2: all outputs return to reset values and no `out_valid` occurs afterwards.
- With `BLINK_ABORT_EN`, pulse `abort` at round 3: IDLE next cycle, `state`=0, `in_ready`=1 and no `out_valid`. Pulsing `abort` together with `in_valid` in IDLE still accepts the block.

Source files
------------

// File: rtl/blink_round_sequencer.sv
// Iterative round controller for Blink-128: whitening on accept, NR shared-datapath rounds, result held until consumed.
// Optional abort input is compiled in with the BLINK_ABORT_EN macro.
module blink_round_sequencer #(
    parameter int NR = 16,
    parameter int CW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [CW-1:0] rk_idx,
    input  logic [127:0]  rk,
    output logic [127:0]  rf_in,
    input  logic [127:0]  rf_out,
    output logic          busy
`ifdef BLINK_ABORT_EN
    ,
    input  logic          abort
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } st_t;

    localparam logic [CW-1:0] NR_C  = CW'(NR);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    st_t           r_st;
    st_t           w_st_next;
    logic [127:0]  r_state;
    logic [127:0]  w_state_next;
    logic [CW-1:0] r_rnd;
    logic [CW-1:0] w_rnd_next;
    logic          w_abort;

`ifdef BLINK_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st    <= ST_IDLE;
            r_state <= '0;
            r_rnd   <= '0;
        end else begin
            r_st    <= w_st_next;
            r_state <= w_state_next;
            r_rnd   <= w_rnd_next;
        end
    end

    // rk is the key-0 value whenever a block is loaded, because rk_idx is 0 outside RUN.
    always_comb begin
        w_st_next    = r_st;
        w_state_next = r_state;
        w_rnd_next   = r_rnd;
        case (r_st)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = in_data ^ rk;
                    w_rnd_next   = ONE_C;
                    w_st_next    = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = rf_out;
                if (r_rnd == NR_C) begin
                    w_st_next = ST_DONE;
                end else begin
                    w_rnd_next = r_rnd + ONE_C;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_next = in_data ^ rk;
                        w_rnd_next   = ONE_C;
                        w_st_next    = ST_RUN;
                    end else begin
                        w_st_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_st_next = ST_IDLE;
            end
        endcase
        if (w_abort && (r_st != ST_IDLE)) begin
            w_st_next    = ST_IDLE;
            w_state_next = '0;
            w_rnd_next   = '0;
        end
    end

    // An abort in DONE cancels the handshake, so the producer must not see ready either.
    always_comb begin
        in_ready = 1'b0;
        case (r_st)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready & ~w_abort;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (r_st == ST_DONE);
    assign busy      = (r_st == ST_RUN);
    assign rk_idx    = (r_st == ST_RUN) ? r_rnd : '0;
    assign out_data  = r_state;
    assign rf_in     = r_state;

endmodule

// File: tb/tb_blink_round_sequencer.sv
// Bench for blink_round_sequencer (NR=4): vector table, hand-written corner sequences and randomized blocks vs. a reference model.
module tb_blink_round_sequencer;

    localparam int NR = 4;
    localparam int CW = $clog2(NR + 1);
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [CW-1:0] rk_idx;
    logic [127:0]  rk;
    logic [127:0]  rf_in;
    logic [127:0]  rf_out;
    logic          busy;
`ifdef BLINK_ABORT_EN
    logic          abort;
`endif

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    logic [127:0] keys [0:(1<<CW)-1];

    blink_round_sequencer #(.NR(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .rf_in     (rf_in),
        .rf_out    (rf_out),
        .busy      (busy)
`ifdef BLINK_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub key store and round function.
    always_comb begin
        rk     = '0;
        rf_out = '0;
        case (mode)
            0: begin
                rk     = '0;
                rf_out = rf_in + 128'd1;
            end
            1: begin
                rk     = {16{8'(rk_idx)}};
                rf_out = rf_in + 128'd1;
            end
            default: begin
                rk     = keys[rk_idx];
                rf_out = {rf_in[126:0], rf_in[127]} ^ rk;
            end
        endcase
    end

    typedef struct {
        logic          rst_n;
        logic          iv;
        logic          ordy;
        logic [7:0]    din;
        logic          e_ir;
        logic          e_ov;
        logic          e_busy;
        logic [CW-1:0] e_idx;
        logic [7:0]    e_data;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(bit r, bit iv, bit o, logic [7:0] d,
                                bit ir, bit ov, bit b, int idx, logic [7:0] ed);
        vec_t v;
        v.rst_n  = r;
        v.iv     = iv;
        v.ordy   = o;
        v.din    = d;
        v.e_ir   = ir;
        v.e_ov   = ov;
        v.e_busy = b;
        v.e_idx  = CW'(idx);
        v.e_data = ed;
        return v;
    endfunction

    // Whitening with key 0, then NR rounds of rotate-left-1 xor round key.
    function automatic logic [127:0] ref_model(logic [127:0] din);
        logic [127:0] s;
        s = din ^ keys[0];
        for (int r = 1; r <= NR; r++) begin
            s = {s[126:0], s[127]} ^ keys[r];
        end
        return s;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] din;
        logic [127:0] exp;
        logic [127:0] held;
        int n;
        int stall;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
`ifdef BLINK_ABORT_EN
        abort     = 1'b0;
`endif
        for (int k = 0; k < (1<<CW); k++) keys[k] = '0;
        tick();
        tick();
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data",  out_data,        128'd0);
        chk("rst_rk_idx",    128'(rk_idx),    128'd0);
        chk("rst_busy",      128'(busy),      128'd0);

        // rst, iv, ordy, din | in_ready, out_valid, busy, rk_idx, out_data
        tbl[0]  = mk(H, L, L, 8'h00, H, L, L, 0, 8'h00);
        tbl[1]  = mk(H, H, L, 8'h10, H, L, L, 0, 8'h00);
        tbl[2]  = mk(H, L, L, 8'h00, L, L, H, 1, 8'h10);
        tbl[3]  = mk(H, L, L, 8'h00, L, L, H, 2, 8'h11);
        tbl[4]  = mk(H, L, L, 8'h00, L, L, H, 3, 8'h12);
        tbl[5]  = mk(H, L, L, 8'h00, L, L, H, 4, 8'h13);
        tbl[6]  = mk(H, L, L, 8'h00, L, H, L, 0, 8'h14);
        tbl[7]  = mk(H, L, L, 8'h00, L, H, L, 0, 8'h14);
        tbl[8]  = mk(H, H, L, 8'h55, L, H, L, 0, 8'h14);
        tbl[9]  = mk(H, L, L, 8'h00, L, H, L, 0, 8'h14);
        tbl[10] = mk(H, L, L, 8'h00, L, H, L, 0, 8'h14);
        tbl[11] = mk(H, H, H, 8'h20, H, H, L, 0, 8'h14);
        tbl[12] = mk(H, H, L, 8'h99, L, L, H, 1, 8'h20);
        tbl[13] = mk(H, L, L, 8'h00, L, L, H, 2, 8'h21);
        tbl[14] = mk(H, L, L, 8'h00, L, L, H, 3, 8'h22);
        tbl[15] = mk(H, L, L, 8'h00, L, L, H, 4, 8'h23);
        tbl[16] = mk(H, L, H, 8'h00, H, H, L, 0, 8'h24);
        tbl[17] = mk(H, L, L, 8'h00, H, L, L, 0, 8'h24);
        tbl[18] = mk(H, H, L, 8'h30, H, L, L, 0, 8'h24);
        tbl[19] = mk(H, L, L, 8'h00, L, L, H, 1, 8'h30);
        tbl[20] = mk(L, L, L, 8'h00, L, L, H, 2, 8'h31);
        for (int k = 21; k < 27; k++) tbl[k] = mk(H, L, L, 8'h00, H, L, L, 0, 8'h00);

        mode = 0;
        for (int i = 0; i < 27; i++) begin
            rst_n     = tbl[i].rst_n;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            in_data   = {120'd0, tbl[i].din};
            #1;
            chk($sformatf("vec%0d_in_ready", i),  128'(in_ready),  128'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
            chk($sformatf("vec%0d_busy", i),      128'(busy),      128'(tbl[i].e_busy));
            chk($sformatf("vec%0d_rk_idx", i),    128'(rk_idx),    128'(tbl[i].e_idx));
            chk($sformatf("vec%0d_out_data", i),  out_data,        {120'd0, tbl[i].e_data});
            $display("vec %0d ir=%0b ov=%0b busy=%0b idx=%0d data=%h", i, in_ready, out_valid, busy, rk_idx, out_data[7:0]);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Whitening must use key 0 even though later keys are non-zero.
        mode     = 1;
        din      = {$urandom, $urandom, $urandom, $urandom};
        in_data  = din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("white_key0", out_data, din);
        for (int k = 0; k < NR; k++) tick();
        chk("white_ov",   128'(out_valid), 128'd1);
        chk("white_data", out_data, din + 128'(NR));
        $display("whiten in=%h out=%h", din, out_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef BLINK_ABORT_EN
        mode     = 0;
        in_data  = 128'h10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_at_round3", 128'(rk_idx), 128'd3);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_busy",      128'(busy),      128'd0);
        chk("abort_in_ready",  128'(in_ready),  128'd1);
        chk("abort_state",     out_data,        128'd0);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 128'h40;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_accept", out_data, 128'h40);
        for (int k = 0; k < NR; k++) tick();
        chk("abort_idle_result", out_data, 128'h44);
        $display("abort sequence data=%h", out_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        mode = 2;
        for (int k = 0; k < (1<<CW); k++) keys[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < 25; b++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            din      = {$urandom, $urandom, $urandom, $urandom};
            in_data  = din;
            in_valid = 1'b1;
            n = 0;
            #1;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) chk("rand_in_ready_timeout", 128'(in_ready), 128'd1);
            tick();
            in_valid = 1'b0;
            exp = ref_model(din);
            n = 0;
            while (!out_valid && n < 50) begin
                tick();
                n++;
            end
            chk($sformatf("rand%0d_latency", b), 128'(n), 128'(NR));
            chk($sformatf("rand%0d_data", b), out_data, exp);
            held  = out_data;
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk($sformatf("rand%0d_hold", b), out_data, held);
                chk($sformatf("rand%0d_hold_ir", b), 128'(in_ready), 128'd0);
            end
            $display("block %0d in=%h out=%h stall=%0d", b, din, out_data, stall);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("rand%0d_released", b), 128'(out_valid), 128'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
